// File: rtl/pkt_fifo_sync.sv
// rtl/pkt_fifo_sync.sv - store-and-forward packet FIFO with commit/rewind and drop
// Optional: define PKT_FIFO_STATS_EN to add the saturating drop_cnt output.
module pkt_fifo_sync #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = DEPTH - 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic                       s_tlast,
  input  logic                       s_tuser,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tlast,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count,
  output logic                       almost_full,
  output logic                       drop_pulse
`ifdef PKT_FIFO_STATS_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {PASS, DROP} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_n, cm_ptr, cm_ptr_n, rd_ptr;
  logic [CNT_W-1:0]   cm_cnt, un_cnt, un_cnt_n, cm_add, pkt_count_r;
  logic               accept, pop, commit, wr_en, drop_n;
  logic [DATA_W:0]    mem [DEPTH];
  logic [DATA_W:0]    rd_word;

  assign level       = cm_cnt + un_cnt;
  assign pkt_count   = pkt_count_r;
  assign almost_full = (level >= CNT_W'(AF_THRESH));
  assign m_tvalid    = (cm_cnt != '0);
  assign rd_word     = mem[rd_ptr];
  assign m_tdata     = rd_word[DATA_W-1:0];
  assign m_tlast     = rd_word[DATA_W];
  assign pop         = m_tvalid && m_tready;
  assign accept      = s_tvalid && s_tready;

  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    cm_ptr_n = cm_ptr;
    un_cnt_n = un_cnt;
    cm_add   = '0;
    commit   = 1'b0;
    wr_en    = 1'b0;
    drop_n   = 1'b0;
    s_tready = (state == DROP) ? 1'b1 : (level < CNT_FULL);
    case (state)
      PASS: begin
        // A packet that has filled the whole store can never complete: rewind and drop the rest.
        if (un_cnt == CNT_FULL) begin
          state_n  = DROP;
          wr_ptr_n = cm_ptr;
          un_cnt_n = '0;
          drop_n   = 1'b1;
        end else if (accept) begin
          wr_en = 1'b1;
          if (s_tlast && s_tuser) begin
            wr_ptr_n = cm_ptr;
            un_cnt_n = '0;
            drop_n   = 1'b1;
          end else if (s_tlast) begin
            commit   = 1'b1;
            wr_ptr_n = wr_ptr + PTR_ONE;
            cm_ptr_n = wr_ptr + PTR_ONE;
            cm_add   = un_cnt + CNT_ONE;
            un_cnt_n = '0;
          end else begin
            wr_ptr_n = wr_ptr + PTR_ONE;
            un_cnt_n = un_cnt + CNT_ONE;
          end
        end
      end
      DROP: begin
        if (accept && s_tlast) state_n = PASS;
      end
      default: state_n = PASS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PASS;
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      rd_ptr      <= '0;
      cm_cnt      <= '0;
      un_cnt      <= '0;
      pkt_count_r <= '0;
      drop_pulse  <= 1'b0;
    end else begin
      state       <= state_n;
      wr_ptr      <= wr_ptr_n;
      cm_ptr      <= cm_ptr_n;
      un_cnt      <= un_cnt_n;
      drop_pulse  <= drop_n;
      cm_cnt      <= cm_cnt + cm_add - CNT_W'(pop);
      pkt_count_r <= pkt_count_r + CNT_W'(commit) - CNT_W'(pop && m_tlast);
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {s_tlast, s_tdata};
  end

`ifdef PKT_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                drop_cnt <= '0;
    else if (drop_pulse && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pkt_fifo_sync.sv
// tb/tb_pkt_fifo_sync.sv - directed and random checks of pkt_fifo_sync against a queue model
module tb_pkt_fifo_sync;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk, rst_n;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DW-1:0] s_tdata, m_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [CW-1:0] level, pkt_count;
  logic          almost_full, drop_pulse;
`ifdef PKT_FIFO_STATS_EN
  logic [15:0]   drop_cnt;
`endif

  pkt_fifo_sync #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .level(level), .pkt_count(pkt_count), .almost_full(almost_full),
    .drop_pulse(drop_pulse)
`ifdef PKT_FIFO_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail = 0;

  // Reference: committed words are a queue, the packet being received is another.
  logic [DW:0] committed[$];
  logic [DW:0] pending[$];
  bit          dropping;
  bit          drop_exp;
  int          drop_total;
  bit          acc_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_level();
    return committed.size() + pending.size();
  endfunction

  function automatic bit m_tready_exp();
    return dropping ? 1'b1 : (m_level() < DEPTH);
  endfunction

  function automatic int m_pkts();
    int n = 0;
    foreach (committed[i]) if (committed[i][DW]) n++;
    return n;
  endfunction

  task automatic model_reset();
    committed.delete();
    pending.delete();
    dropping = 0;
    drop_exp = 0;
    drop_total = 0;
  endtask

  task automatic check_all();
    chk("s_tready", s_tready, m_tready_exp());
    chk("m_tvalid", m_tvalid, committed.size() != 0);
    chk("level", level, m_level());
    chk("pkt_count", pkt_count, m_pkts());
    chk("almost_full", almost_full, m_level() >= AF);
    chk("drop_pulse", drop_pulse, drop_exp);
`ifdef PKT_FIFO_STATS_EN
    chk("drop_cnt", drop_cnt, drop_total);
`endif
    if (committed.size() != 0) begin
      chk("m_tdata", m_tdata, committed[0][DW-1:0]);
      chk("m_tlast", m_tlast, committed[0][DW]);
    end
  endtask

  task automatic model_edge();
    bit acc, nd;
    acc = s_tvalid && m_tready_exp();
    nd = 0;
    if (m_tready && committed.size() != 0) void'(committed.pop_front());
    if (!dropping) begin
      if (pending.size() == DEPTH) begin
        pending.delete();
        dropping = 1;
        nd = 1;
      end else if (acc) begin
        if (s_tlast && s_tuser) begin
          pending.delete();
          nd = 1;
        end else begin
          pending.push_back({s_tlast, s_tdata});
          if (s_tlast) begin
            foreach (pending[i]) committed.push_back(pending[i]);
            pending.delete();
          end
        end
      end
    end else if (acc && s_tlast) begin
      dropping = 0;
    end
    if (drop_exp && drop_total < 16'hFFFF) drop_total++;
    drop_exp = nd;
    acc_last = acc;
  endtask

  task automatic tick();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input logic u);
    int n;
    n = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l; s_tuser = u;
    do begin
      tick();
      n++;
    end while (!acc_last && n < 50);
    chk("send_accept", acc_last, 1'b1);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_tready = 1'b1;
    while (committed.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drained", committed.size(), 0);
    m_tready = 1'b0;
    tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_s_tready", s_tready, 1'b1);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_almost_full", almost_full, 1'b0);
    chk("rst_drop_pulse", drop_pulse, 1'b0);
`ifdef PKT_FIFO_STATS_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pkt_len, beat_idx;
    s_tvalid = 0; s_tdata = '0; s_tlast = 0; s_tuser = 0; m_tready = 0;
    apply_reset();

    // Packet visible only after its last beat, delivered in order.
    send_beat(32'hA1, 0, 0);
    send_beat(32'hA2, 0, 1);
    chk("t1_not_visible", m_tvalid, 1'b0);
    send_beat(32'hA3, 1, 0);
    chk("t1_visible", m_tvalid, 1'b1);
    chk("t1_pkt_count", pkt_count, 1);
    chk("t1_level", level, 3);
    chk("t1_head", m_tdata, 32'hA1);
    drain();
    chk("t1_pkt_after", pkt_count, 0);

    // Error packet discarded, following good packet intact.
    for (int i = 0; i < 4; i++) send_beat(32'hE0 + i, i == 3, i == 3);
    chk("t2_drop_pulse", drop_pulse, 1'b1);
    chk("t2_level", level, 0);
    tick();
    chk("t2_pulse_once", drop_pulse, 1'b0);
    send_beat(32'hB1, 0, 0);
    send_beat(32'hB2, 1, 0);
    drain();

    // Oversized packet overflows into DROP.
    for (int i = 0; i < 8; i++) send_beat(32'hC0 + i, 0, 0);
    chk("t3_full", s_tready, 1'b0);
    chk("t3_level8", level, 8);
    send_beat(32'hC8, 0, 0);
    chk("t3_level0", level, 0);
    send_beat(32'hC9, 1, 0);
    send_beat(32'hD1, 0, 0);
    send_beat(32'hD2, 1, 0);
    chk("t3_next_pkt", pkt_count, 1);
    drain();

    // Last-beat pop coincides with commit of the next packet.
    for (int i = 0; i < 3; i++) send_beat(32'h10 + i, i == 2, 0);
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(32'h20 + i, i == 2, 0);
    chk("t4_pkt_count", pkt_count, 1);
    chk("t4_level", level, 3);
    drain();

    // almost_full threshold.
    for (int i = 0; i < 6; i++) send_beat(32'h30 + i, i == 5, 0);
    chk("t5_af_on", almost_full, 1'b1);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    chk("t5_af_off", almost_full, 1'b0);
    drain();

    // Reset mid-packet.
    for (int i = 0; i < 3; i++) send_beat(32'h40 + i, i == 2, 0);
    send_beat(32'h50, 0, 0);
    send_beat(32'h51, 0, 0);
    chk("t6_level5", level, 5);
    apply_reset();
    for (int i = 0; i < 3; i++) send_beat(32'h60 + i, i == 2, 0);
    chk("t6_post_reset", level, 3);
    drain();
    send_beat(32'h70, 1, 1);
    send_beat(32'h71, 1, 1);
    tick();
    tick();
`ifdef PKT_FIFO_STATS_EN
    chk("t6_drop_cnt2", drop_cnt, 2);
`endif

    // Random traffic against the model.
    pkt_len = 3;
    beat_idx = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!s_tvalid && $urandom_range(3) != 0) begin
        s_tvalid = 1'b1;
        s_tdata = $urandom;
        s_tlast = (beat_idx == pkt_len - 1);
        s_tuser = s_tlast ? ($urandom_range(7) == 0) : $urandom_range(1);
      end
      m_tready = ($urandom_range(2) != 0);
      tick();
      if (acc_last) begin
        s_tvalid = 1'b0;
        if (beat_idx == pkt_len - 1) begin
          beat_idx = 0;
          pkt_len = $urandom_range(1, 12);
        end else begin
          beat_idx++;
        end
      end
    end
    s_tvalid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
